// File: rtl/fifo_rom_lookup_pipe_pkg.sv
// Shared defaults and FIFO word field layout for the pipelined FIFO-to-ROM lookup block.
// A FIFO word is {tag, index}, with the index in the low bits.
package fifo_rom_lookup_pipe_pkg;

  localparam int DEF_TAG_W = 4;
  localparam int DEF_IDX_W = 8;
  localparam int DEF_AW    = 8;
  localparam int DEF_DW    = 32;
  localparam int DEF_DEPTH = 4;
  localparam int DEF_CNT_W = 16;

  localparam int IDX_LSB = 0;

  function automatic int idx_msb(int idx_w);
    return idx_w - 1;
  endfunction

  function automatic int tag_lsb(int idx_w);
    return idx_w;
  endfunction

  function automatic int tag_msb(int tag_w, int idx_w);
    return tag_w + idx_w - 1;
  endfunction

endpackage

// File: rtl/fifo_rom_lookup_pipe_if.sv
// Bus bundle for the lookup pipe: index FIFO side, ROM side, result stream and status.
// The slave modport is the lookup block; the master modport is its environment.
interface fifo_rom_lookup_pipe_if
  import fifo_rom_lookup_pipe_pkg::*;
#(
  parameter int TAG_W = DEF_TAG_W,
  parameter int IDX_W = DEF_IDX_W,
  parameter int AW    = DEF_AW,
  parameter int DW    = DEF_DW,
  parameter int CNT_W = DEF_CNT_W
);

  logic                   enable;
  logic                   fifo_empty;
  logic [TAG_W+IDX_W-1:0] fifo_data;
  logic                   fifo_rd_en;
  logic [AW-1:0]          base_addr;
  logic [AW-1:0]          rom_addr;
  logic                   rom_ce;
  logic [DW-1:0]          rom_data;
  logic                   rom_data_valid;
  logic                   result_valid;
  logic                   result_ready;
  logic [TAG_W+DW-1:0]    result;
  logic                   busy;
  logic                   order_err;
  logic [CNT_W-1:0]       lookup_cnt;

  modport slave (
    input  enable, fifo_empty, fifo_data, base_addr, rom_data, rom_data_valid, result_ready,
    output fifo_rd_en, rom_addr, rom_ce, result_valid, result, busy, order_err, lookup_cnt
  );

  modport master (
    output enable, fifo_empty, fifo_data, base_addr, rom_data, rom_data_valid, result_ready,
    input  fifo_rd_en, rom_addr, rom_ce, result_valid, result, busy, order_err, lookup_cnt
  );

endinterface

// File: rtl/fifo_rom_lookup_pipe_sync_fifo.sv
// Parametrised synchronous FIFO with first-word-fall-through read data.
// Push on full is accepted only together with a pop; pop on empty is ignored.
module lookup_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign pop_data = mem_q[rd_ptr_q];
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/fifo_rom_lookup_pipe.sv
// Pipelined FIFO-to-ROM reader: one lookup issued per cycle, up to DEPTH outstanding,
// results returned in issue order as {tag, rom_data} on a valid/ready stream.
module fifo_rom_lookup_pipe
  import fifo_rom_lookup_pipe_pkg::*;
#(
  parameter int TAG_W = DEF_TAG_W,
  parameter int IDX_W = DEF_IDX_W,
  parameter int AW    = DEF_AW,
  parameter int DW    = DEF_DW,
  parameter int DEPTH = DEF_DEPTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input logic                   clk,
  input logic                   rst,
  fifo_rom_lookup_pipe_if.slave bus
);

  localparam int RW    = TAG_W + DW;
  localparam int CRW   = $clog2(DEPTH + 1);
  localparam int I_MSB = idx_msb(IDX_W);
  localparam int T_LSB = tag_lsb(IDX_W);
  localparam int T_MSB = tag_msb(TAG_W, IDX_W);

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             issue, handshake;

  logic             rom_ce_q, rom_ce_d;
  logic [AW-1:0]    rom_addr_q, rom_addr_d;
  logic [CRW-1:0]   credit_q, credit_d;
  logic             order_err_q, order_err_d;
  logic [CNT_W-1:0] lookup_cnt_q, lookup_cnt_d;

  logic [TAG_W-1:0] tq_head;
  logic             tq_full, tq_empty, tq_pop;
  logic [RW-1:0]    rb_head;
  logic             rb_full, rb_empty, rb_push;

  assign idx = bus.fifo_data[I_MSB:IDX_LSB];
  assign tag = bus.fifo_data[T_MSB:T_LSB];

  // Credit counts free slots across ROM-in-flight and the result buffer together.
  assign issue     = bus.enable && !bus.fifo_empty && (credit_q != '0);
  assign handshake = !rb_empty && bus.result_ready;
  assign tq_pop    = bus.rom_data_valid && !tq_empty;
  assign rb_push   = tq_pop;

  always_comb begin
    rom_ce_d     = issue;
    rom_addr_d   = issue ? (bus.base_addr + AW'(idx)) : rom_addr_q;
    order_err_d  = order_err_q || (bus.rom_data_valid && tq_empty);
    lookup_cnt_d = lookup_cnt_q + CNT_W'(handshake);
    unique case ({issue, handshake})
      2'b10:   credit_d = credit_q - CRW'(1);
      2'b01:   credit_d = credit_q + CRW'(1);
      default: credit_d = credit_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_ce_q     <= 1'b0;
      rom_addr_q   <= '0;
      credit_q     <= CRW'(DEPTH);
      order_err_q  <= 1'b0;
      lookup_cnt_q <= '0;
    end else begin
      rom_ce_q     <= rom_ce_d;
      rom_addr_q   <= rom_addr_d;
      credit_q     <= credit_d;
      order_err_q  <= order_err_d;
      lookup_cnt_q <= lookup_cnt_d;
    end
  end

  lookup_sync_fifo #(.W(TAG_W), .DEPTH(DEPTH)) u_tag_q (
    .clk       (clk),
    .rst       (rst),
    .push      (issue),
    .push_data (tag),
    .pop       (tq_pop),
    .pop_data  (tq_head),
    .full      (tq_full),
    .empty     (tq_empty)
  );

  lookup_sync_fifo #(.W(RW), .DEPTH(DEPTH)) u_result_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (rb_push),
    .push_data ({tq_head, bus.rom_data}),
    .pop       (handshake),
    .pop_data  (rb_head),
    .full      (rb_full),
    .empty     (rb_empty)
  );

  assign bus.fifo_rd_en   = issue;
  assign bus.rom_ce       = rom_ce_q;
  assign bus.rom_addr     = rom_addr_q;
  assign bus.result_valid = !rb_empty;
  assign bus.result       = rb_empty ? '0 : rb_head;
  assign bus.busy         = (credit_q != CRW'(DEPTH));
  assign bus.order_err    = order_err_q;
  assign bus.lookup_cnt   = lookup_cnt_q;

  // The credit scheme guarantees neither queue is ever pushed while full without a matching pop.
  a_tq_no_overflow : assert property (@(posedge clk) disable iff (rst) !(issue && tq_full));
  a_rb_no_overflow : assert property (@(posedge clk) disable iff (rst)
                                      !(rb_push && rb_full && !handshake));

endmodule
